// File: rtl/jtframe_ram_pkg.sv
// Shared definitions for the jtframe RAM layer: read-during-write modes,
// clear-sweep FSM states and the byte-lane merge helper.
package jtframe_ram_pkg;

    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

    // Widest data bus the merge helper supports.
    localparam int MAX_DW = 256;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CLR  = 2'd1,
        DONE = 2'd2
    } clr_state_t;

    // Replaces the bytes of old_word selected by be with those of new_word.
    // Only the low dw/8 lanes are considered.
    function automatic logic [MAX_DW-1:0] byte_merge(
        input int                  dw,
        input logic [MAX_DW-1:0]   old_word,
        input logic [MAX_DW-1:0]   new_word,
        input logic [MAX_DW/8-1:0] be
    );
        logic [MAX_DW-1:0] merged;
        merged = old_word;
        for (int i = 0; i < MAX_DW/8; i++) begin
            if (i < dw/8 && be[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/jtframe_dual_ram_be_if.sv
// Two-port RAM bus: port A and port B request signals plus registered read data.
interface jtframe_dual_ram_be_if #(
    parameter int DW = 16,
    parameter int AW = 10
);

    logic            cen_a;
    logic [AW-1:0]   addr_a;
    logic [DW-1:0]   data_a;
    logic            we_a;
    logic [DW/8-1:0] be_a;
    logic [DW-1:0]   q_a;

    logic            cen_b;
    logic [AW-1:0]   addr_b;
    logic [DW-1:0]   data_b;
    logic            we_b;
    logic [DW/8-1:0] be_b;
    logic [DW-1:0]   q_b;

    modport master (
        output cen_a, addr_a, data_a, we_a, be_a,
        output cen_b, addr_b, data_b, we_b, be_b,
        input  q_a, q_b
    );

    modport slave (
        input  cen_a, addr_a, data_a, we_a, be_a,
        input  cen_b, addr_b, data_b, we_b, be_b,
        output q_a, q_b
    );

endinterface

// File: rtl/jtframe_ram_clr.sv
// Post-reset clear sweep: walks every address once, one word per cycle,
// and holds busy until the last address has been written.
module jtframe_ram_clr
    import jtframe_ram_pkg::*;
#(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic          busy,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr
);

    clr_state_t state;

    // The IDLE cycle after reset release already writes address 0, so the
    // whole sweep spans exactly 2**AW cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            clr_addr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    state    <= CLR;
                    clr_addr <= clr_addr + AW'(1);
                end
                CLR: begin
                    if (clr_addr == '1) begin
                        state <= DONE;
                    end else begin
                        clr_addr <= clr_addr + AW'(1);
                    end
                end
                DONE:    state <= DONE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy   = (state != DONE);
    assign clr_we = rst_n && (state != DONE);

endmodule

// File: rtl/jtframe_dual_ram_be.sv
// Single-clock true dual-port RAM with byte enables and per-port read-during-write.
// Define JTFRAME_RAM_CLR_EN to build the post-reset clear sweep and busy output.
module jtframe_dual_ram_be
    import jtframe_ram_pkg::*;
#(
    parameter int             DW      = 16,
    parameter int             AW      = 10,
    parameter int             RDW_A   = 0,
    parameter int             RDW_B   = 0,
    parameter logic [DW-1:0]  CLR_VAL = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    jtframe_dual_ram_be_if.slave  bus,
    output logic                  busy
);

    localparam int DEPTH = 2**AW;
    localparam int BW    = DW/8;

`ifdef SIMULATION
    logic [DW-1:0] mem [DEPTH] = '{default: '0};
`else
    logic [DW-1:0] mem [DEPTH];
`endif

    logic          clr_we;
    logic [AW-1:0] clr_addr;

`ifdef JTFRAME_RAM_CLR_EN
    jtframe_ram_clr #(.AW(AW)) u_clr (
        .clk      (clk),
        .rst_n    (rst_n),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );
`else
    assign busy     = 1'b0;
    assign clr_we   = 1'b0;
    assign clr_addr = '0;
`endif

    logic          open;
    logic          wr_a, wr_b, collide;
    logic [DW-1:0] old_a, old_b, new_a, new_b, wdata_a;

    always_comb begin
        open    = rst_n && !busy;
        wr_a    = open && bus.cen_a && bus.we_a && (|bus.be_a);
        wr_b    = open && bus.cen_b && bus.we_b && (|bus.be_b);
        collide = wr_a && wr_b && (bus.addr_a == bus.addr_b);
        old_a   = mem[bus.addr_a];
        old_b   = mem[bus.addr_b];
        new_a   = DW'(byte_merge(DW, MAX_DW'(old_a), MAX_DW'(bus.data_a), (MAX_DW/8)'(bus.be_a)));
        new_b   = DW'(byte_merge(DW, MAX_DW'(old_b), MAX_DW'(bus.data_b), (MAX_DW/8)'(bus.be_b)));
        // On a same-address collision port A commits a single word: B's lanes
        // first, then A's lanes on top, so A wins any lane both enable.
        wdata_a = collide
                ? DW'(byte_merge(DW, MAX_DW'(new_b), MAX_DW'(bus.data_a), (MAX_DW/8)'(bus.be_a)))
                : new_a;
    end

    // NOTE: the array has no reset branch; reset must never touch contents,
    // and a reset on a memory would block RAM-block inference.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= CLR_VAL;
        end else begin
            if (wr_b && !collide) mem[bus.addr_b] <= new_b;
            if (wr_a)             mem[bus.addr_a] <= wdata_a;
        end
    end

    // Reads sample the pre-edge array, so cross-port reads always see old data.
    always_ff @(posedge clk) begin
        if (!rst_n || busy) begin
            bus.q_a <= '0;
            bus.q_b <= '0;
        end else begin
            if (bus.cen_a) begin
                bus.q_a <= (RDW_A == RDW_NEW && bus.we_a) ? new_a : old_a;
            end
            if (bus.cen_b) begin
                bus.q_b <= (RDW_B == RDW_NEW && bus.we_b) ? new_b : old_b;
            end
        end
    end

    logic unused_bw;
    assign unused_bw = (BW == 0);

endmodule

// File: tb/tb_jtframe_dual_ram_be.sv
// Self-checking bench for jtframe_dual_ram_be: two instances (old-data and
// new-data read-during-write) driven identically and compared to a word model.
module tb_jtframe_dual_ram_be;

    localparam int          DW      = 16;
    localparam int          AW      = 4;
    localparam int          DEPTH   = 16;
    localparam logic [15:0] CLR_VAL = 16'hA5A5;
`ifdef JTFRAME_RAM_CLR_EN
    localparam int          SWEEP   = DEPTH;
`else
    localparam int          SWEEP   = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy0, busy1;

    jtframe_dual_ram_be_if #(.DW(DW), .AW(AW)) if0 ();
    jtframe_dual_ram_be_if #(.DW(DW), .AW(AW)) if1 ();

    jtframe_dual_ram_be #(.DW(DW), .AW(AW), .RDW_A(0), .RDW_B(0), .CLR_VAL(CLR_VAL)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(if0.slave), .busy(busy0)
    );
    jtframe_dual_ram_be #(.DW(DW), .AW(AW), .RDW_A(1), .RDW_B(1), .CLR_VAL(CLR_VAL)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(if1.slave), .busy(busy1)
    );

    always #5 clk = ~clk;

    // stimulus
    logic        cen_a = 0, we_a = 0, cen_b = 0, we_b = 0;
    logic [3:0]  addr_a = 0, addr_b = 0;
    logic [15:0] data_a = 0, data_b = 0;
    logic [1:0]  be_a = 0, be_b = 0;

    // reference model
    logic [15:0] ref_mem [DEPTH];
    int          sweep_left = SWEEP;
    logic [15:0] exp_qa0 = 0, exp_qa1 = 0, exp_qb0 = 0, exp_qb1 = 0;
    bit          chk_q = 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_ports();
        cen_a = 0; we_a = 0; be_a = 0;
        cen_b = 0; we_b = 0; be_b = 0;
    endtask

    // One clock: drive both DUTs, predict, clock, compare.
    task automatic step(input string tag);
        logic [15:0] old_a, old_b, mrg_a, mrg_b;
        bit          active, exp_busy;
        if0.cen_a = cen_a; if0.we_a = we_a; if0.addr_a = addr_a; if0.data_a = data_a; if0.be_a = be_a;
        if0.cen_b = cen_b; if0.we_b = we_b; if0.addr_b = addr_b; if0.data_b = data_b; if0.be_b = be_b;
        if1.cen_a = cen_a; if1.we_a = we_a; if1.addr_a = addr_a; if1.data_a = data_a; if1.be_a = be_a;
        if1.cen_b = cen_b; if1.we_b = we_b; if1.addr_b = addr_b; if1.data_b = data_b; if1.be_b = be_b;

        active = rst_n && (sweep_left == 0);
        old_a  = ref_mem[addr_a];
        old_b  = ref_mem[addr_b];
        mrg_a  = old_a;
        mrg_b  = old_b;
        for (int l = 0; l < 2; l++) begin
            if (be_a[l]) mrg_a[8*l +: 8] = data_a[8*l +: 8];
            if (be_b[l]) mrg_b[8*l +: 8] = data_b[8*l +: 8];
        end

        if (!active) begin
            exp_qa0 = 0; exp_qa1 = 0; exp_qb0 = 0; exp_qb1 = 0;
        end else begin
            if (cen_a) begin exp_qa0 = old_a; exp_qa1 = we_a ? mrg_a : old_a; end
            if (cen_b) begin exp_qb0 = old_b; exp_qb1 = we_b ? mrg_b : old_b; end
            // B lands first, A's enabled lanes override it
            if (cen_b && we_b) ref_mem[addr_b] = mrg_b;
            if (cen_a && we_a) begin
                for (int l = 0; l < 2; l++)
                    if (be_a[l]) ref_mem[addr_a][8*l +: 8] = data_a[8*l +: 8];
            end
        end

        if (!rst_n) begin
            sweep_left = SWEEP;
        end else if (sweep_left > 0) begin
            sweep_left--;
            if (sweep_left == 0)
                for (int i = 0; i < DEPTH; i++) ref_mem[i] = CLR_VAL;
        end
        exp_busy = (SWEEP != 0) && (!rst_n || sweep_left > 0);

        @(posedge clk);
        #1;
        check({tag, ".busy0"}, {15'd0, busy0}, {15'd0, exp_busy});
        check({tag, ".busy1"}, {15'd0, busy1}, {15'd0, exp_busy});
        if (chk_q) begin
            check({tag, ".q_a/old"}, if0.q_a, exp_qa0);
            check({tag, ".q_a/new"}, if1.q_a, exp_qa1);
            check({tag, ".q_b/old"}, if0.q_b, exp_qb0);
            check({tag, ".q_b/new"}, if1.q_b, exp_qb1);
        end
    endtask

    initial begin
        // reset and sweep
        rst_n = 0;
        idle_ports();
        repeat (3) step("reset");
        rst_n = 1;
        repeat (DEPTH) step("sweep");

`ifndef JTFRAME_RAM_CLR_EN
        // no sweep: give every word a known value first
        chk_q = 0;
        for (int i = 0; i < DEPTH; i++) begin
            cen_a = 1; we_a = 1; be_a = 2'b11; addr_a = 4'(i); data_a = 16'($urandom);
            step("fill");
        end
        chk_q = 1;
        idle_ports();
`endif

        // read every word on both ports
        for (int i = 0; i < DEPTH; i++) begin
            cen_a = 1; addr_a = 4'(i); cen_b = 1; addr_b = 4'(DEPTH - 1 - i);
            step("read_all");
`ifdef JTFRAME_RAM_CLR_EN
            check("clr_val", if0.q_a, 16'hA5A5);
`endif
        end
        idle_ports();

        // partial write on A, read back on B
        cen_a = 1; we_a = 1; addr_a = 3; data_a = 16'h1234; be_a = 2'b01;
        step("pw_write");
        idle_ports();
        cen_b = 1; addr_b = 3;
        step("pw_read");
`ifdef JTFRAME_RAM_CLR_EN
        check("pw_const", if0.q_b, 16'hA534);
`endif

        // same-port read-during-write
        idle_ports();
        cen_a = 1; we_a = 1; addr_a = 5; data_a = 16'hBEEF; be_a = 2'b11;
        step("rdw");
`ifdef JTFRAME_RAM_CLR_EN
        check("rdw_old", if0.q_a, 16'hA5A5);
`endif
        check("rdw_new", if1.q_a, 16'hBEEF);

        // write collision, full lanes then A low lane only
        cen_a = 1; we_a = 1; addr_a = 7; data_a = 16'h1111; be_a = 2'b11;
        cen_b = 1; we_b = 1; addr_b = 7; data_b = 16'h2222; be_b = 2'b11;
        step("col_full_wr");
        idle_ports();
        cen_a = 1; addr_a = 7;
        step("col_full_rd");
        check("col_full", if0.q_a, 16'h1111);
        cen_a = 1; we_a = 1; addr_a = 7; data_a = 16'h1111; be_a = 2'b01;
        cen_b = 1; we_b = 1; addr_b = 7; data_b = 16'h2222; be_b = 2'b11;
        step("col_part_wr");
        idle_ports();
        cen_b = 1; addr_b = 7;
        step("col_part_rd");
        check("col_part", if0.q_b, 16'h2211);

        // cen gating on port B
        idle_ports();
        cen_b = 1; addr_b = 7;
        step("cen_prime");
        cen_b = 0; we_b = 1; addr_b = 9; data_b = 16'hDEAD; be_b = 2'b11;
        step("cen_hold");
        check("cen_hold_const", if0.q_b, 16'h2211);
        idle_ports();
        cen_b = 1; addr_b = 9;
        step("cen_readback");

        // randomized traffic, addresses often narrowed to force collisions
        for (int n = 0; n < 300; n++) begin
            cen_a  = 1'($urandom_range(0, 3) != 0);
            cen_b  = 1'($urandom_range(0, 3) != 0);
            we_a   = 1'($urandom);
            we_b   = 1'($urandom);
            be_a   = 2'($urandom);
            be_b   = 2'($urandom);
            data_a = 16'($urandom);
            data_b = 16'($urandom);
            if (n % 2 == 0) begin
                addr_a = 4'($urandom_range(0, 3));
                addr_b = 4'($urandom_range(0, 3));
            end else begin
                addr_a = 4'($urandom);
                addr_b = 4'($urandom);
            end
            step("random");
        end

        // reset mid-sweep, then a write attempted while busy
        idle_ports();
        rst_n = 0;
        step("rst2");
        rst_n = 1;
        repeat (9) step("sweep_part");
        rst_n = 0;
        step("rst_mid");
        rst_n = 1;
        cen_a = 1; we_a = 1; be_a = 2'b11; addr_a = 12; data_a = 16'h0000;
        repeat (DEPTH) step("busy_wr");
        idle_ports();
        cen_a = 1; addr_a = 12;
        step("busy_wr_rd");
`ifdef JTFRAME_RAM_CLR_EN
        check("busy_wr_lost", if0.q_a, 16'hA5A5);
`endif

        // final sweep of contents
        for (int i = 0; i < DEPTH; i++) begin
            cen_a = 1; addr_a = 4'(i); cen_b = 1; addr_b = 4'(i ^ 5);
            step("final_read");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/jtframe_dual_ram_be.md
# jtframe_dual_ram_be

Single-clock true dual-port RAM for the jtframe memory layer, the parametrised successor of the dual-clock RAM. Adds byte-lane write enables, a per-port read-during-write mode, a defined write-collision policy and an optional hardware clear sweep after reset. Used for palette, object and work RAM shared between a CPU port and a video/DMA port running on the same clock.

## Interface
- DW, 16: data width; must be a multiple of 8.
- AW, 10: address width; depth is 2**AW words.
- RDW_A, 0: port A read-during-write mode; 0 returns old data, 1 returns new data.
- RDW_B, 0: port B read-during-write mode; same encoding.
- CLR_VAL, 0: DW-bit value written by the clear sweep.

- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- cen_a  in  1  port A clock enable.
- addr_a  in  AW  port A address.
- data_a  in  DW  port A write data.
- we_a  in  1  port A write strobe.
- be_a  in  DW/8  port A byte enables; bit i gates data_a[8i+7:8i].
- q_a  out  DW  port A registered read data.
- cen_b, addr_b, data_b, we_b, be_b, q_b: port B, identical to port A.
- busy  out  1  high while reset is asserted or the clear sweep runs.

## Operation
- Port X acts only in cycles with cen_X=1; with cen_X=0, q_X holds and no write occurs.
- Write: we_X=1 and cen_X=1 updates only lanes with be_X[i]=1; we_X=1 with be_X=0 writes nothing.
- Same-port read-during-write: RDW_X=0 gives the pre-write word; RDW_X=1 gives the merged word, i.e. new bytes in enabled lanes and old bytes elsewhere.
- Cross-port read of an address the other port writes in the same cycle always returns the old word.
- Both ports writing one address in the same cycle: lanes enabled on port A take data_a; lanes enabled only on port B take data_b.
- Clear sweep state machine:
  - IDLE to CLR on the first cycle with rst_n=1 after reset.
  - CLR writes CLR_VAL to address 0, 1, ... 2**AW-1, one word per cycle, regardless of cen.
  - CLR to DONE after the last address; DONE is permanent until the next reset.
- While busy=1: port writes are ignored, and q_a and q_b read 0.
- rst_n=0 at any time, including mid-sweep, returns to IDLE; the sweep restarts from address 0.
- Memory contents are not altered by reset itself.

## Timing
- Reset values: q_a=0, q_b=0; busy=1 (0 with clear compiled out).
- Read latency is one cycle: address at edge N gives data on q_X after edge N.
- Write is visible to either port on the first read edge after the write edge.
- Sweep takes exactly 2**AW cycles. busy falls on the edge that writes the last address, so the first port access is accepted 2**AW cycles after rst_n rises.
- No combinational path from any input to any output.

## Configuration
- JTFRAME_RAM_CLR_EN defined: clear sweep, busy logic and write blocking are built as described.
- JTFRAME_RAM_CLR_EN undefined: no sweep; busy is tied to 0; ports are usable on the first cycle after reset; memory powers up undefined, or 0 under SIMULATION.

## Structure
- Shared package jtframe_ram_pkg holds:
  - RDW_OLD=0 and RDW_NEW=1 constants.
  - The clear FSM state enum (IDLE, CLR, DONE).
  - A function returning the byte-merge of old word, new word and byte enable for a given DW.
- One sub-module, jtframe_ram_clr: the sweep FSM plus AW-bit address counter, producing busy, clr_we and clr_addr. It is instantiated only under JTFRAME_RAM_CLR_EN.
- The memory array and port logic stay in the top module.

## Test plan
Tests run at DW=16, AW=4, CLR_VAL=16'hA5A5.
- Reset then release: busy stays high for 16 cycles after rst_n rises, then falls; reading addresses 0..15 returns A5A5 on every word.
- Partial write: port A writes 16'h1234 to address 3 with be_a=2'b01; port B then reads address 3 and gets A534.
- Same-port read-during-write: write BEEF to address 5 (old value A5A5) while reading it. RDW_A=0 gives q_a=A5A5; RDW_A=1 gives q_a=BEEF.
- Collision: in one cycle, A writes 1111 with be=11 and B writes 2222 with be=11, both to address 7. The next read gives 1111. Repeat with be_a=01 and be_b=11; the read gives 2211.
- Reset mid-sweep: drop rst_n at sweep address 9. After release, busy stays high for a full 16 cycles. A write attempted while busy is lost, and the word reads A5A5.
- cen gating: hold cen_b=0 while presenting a new address and we_b=1. q_b holds its value and the memory word is unchanged.
